mips32_mem_dump: RTL
====================

Name: mips32_mem_dump

Overview:
- Reader-side counterpart to program/data preload: after the pipe_MIPS32 core halts, this block reads a window of data memory through a synchronous read port.
- Each 32-bit word is serialised as 4 bytes, MSB first, over a valid/ready byte stream toward a host/UART/bench monitor.
- Replaces hierarchical peeking of Mem[] (e.g. Mem[198] result checks) with a real hardware readout path.

Parameters:
- ADDR_W, 10, memory word-address width (1024 words); addresses wrap modulo 2^ADDR_W.
- CNT_W, 11, width of word_count (ADDR_W+1, so a full-memory dump is expressible).

Ports:
- clk1  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- start_addr  in  ADDR_W  first word address, latched on accepted start.
- word_count  in  CNT_W  number of words to dump, latched on accepted start.
- mem_rd_en  out  1  memory read strobe.
- mem_rd_addr  out  ADDR_W  memory word address.
- mem_rd_data  in  32  read data, valid the cycle after mem_rd_en.
- out_valid  out  1  byte available.
- out_ready  in  1  sink accepts byte.
- out_data  out  8  byte payload.
- busy  out  1  dump in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset, synchronous on rst_n=0 at the clk1 edge: state=IDLE; mem_rd_en=0, mem_rd_addr=0, out_valid=0, out_data=0, busy=0, done=0. Reset mid-dump abandons it; no further bytes are emitted.
- States: IDLE, READ, WAIT, SEND, CSUM (macro only), DONE.
- IDLE: on start=1, latch addr and remaining count.
  - If word_count=0: go to DONE; no mem_rd_en, no out_valid.
  - Otherwise: go to READ with busy=1.
- READ: one cycle with mem_rd_en=1, mem_rd_addr=addr; then go to WAIT.
- WAIT: capture mem_rd_data into a 32-bit shift register at the end of this cycle; go to SEND with out_valid=1 and out_data=word[31:24], byte index=0.
- Latency: the first out_valid is registered and appears 3 cycles after the start-accept edge when out_ready=1.
- SEND, byte transfer on out_valid && out_ready:
  - Advance to the next byte (word[23:16], [15:8], [7:0]).
  - out_data and out_valid hold stable while out_valid && !out_ready.
  - After byte 3 transfers: decrement remaining and increment addr (wrap 2^ADDR_W-1 -> 0).
  - If remaining>0: out_valid=0, go to READ. Otherwise go to DONE (or CSUM when enabled).
  - There is no gap within a word. Between words there is a 2-cycle bubble (READ, WAIT).
- DONE: done=1 for exactly one cycle, busy=0 in the same cycle, then return to IDLE.
- busy stays high from the cycle after start-accept through the last SEND/CSUM cycle.
- start while busy: ignored, with no effect on latched values.
- out_ready=1 while out_valid=0: ignored.
- mem_rd_en is never asserted outside READ.

Optional Feature:
- Macro: MEM_DUMP_CHECKSUM_EN.
- When defined:
  - A 32-bit XOR accumulator clears on start-accept and XORs in each captured word.
  - After the last data byte, state CSUM emits the accumulator as 4 bytes, MSB first, with the same handshake rules.
  - DONE follows after CSUM.
  - For word_count=0, no checksum is sent.
- When undefined: CSUM and the accumulator are absent; DONE follows the last data byte directly.

Test Plan:
1. Mem[198]=5040, start_addr=198, word_count=1, out_ready=1 -> bytes 00,00,13,B0 on consecutive cycles; first byte 3 cycles after the start edge; done pulses once; mem_rd_en high exactly one cycle with addr 198.
2. Mem[198]=5040, Mem[199]=0, Mem[200]=7, count=3, out_ready toggling 1-0-1 randomly -> 12 bytes 00 00 13 B0 00 00 00 00 00 00 00 07. out_data is held unchanged across every stalled cycle.
3. word_count=0 -> done pulse one cycle later; busy never 1; no mem_rd_en; no out_valid.
4. start_addr=1023, count=2, Mem[1023]=0xDEADBEEF, Mem[0]=0x280A00C8 -> read addrs 1023 then 0; bytes DE AD BE EF 28 0A 00 C8.
5. Assert rst_n=0 for one cycle after 2 bytes of a 3-word dump -> next cycle out_valid=0, busy=0, done=0. A fresh start on count=1 then dumps correctly, with no stale bytes.
6. With MEM_DUMP_CHECKSUM_EN, Mem[200]=7, Mem[201]=5040, count=2 -> 8 data bytes, then 00 00 13 B7, then the done pulse. Also: start pulsed during the dump is ignored.

Source files
------------

// File: rtl/mips32_mem_dump.sv
// Post-halt data-memory readout: reads a window of words through a synchronous
// read port and streams each word MSB-first as bytes. Define MEM_DUMP_CHECKSUM_EN
// to append a 4-byte XOR checksum of all dumped words.
module mips32_mem_dump #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 11
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [31:0]       mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_SEND,
`ifdef MEM_DUMP_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [31:0]       shift_q, shift_d;
    logic [1:0]        idx_q, idx_d;
`ifdef MEM_DUMP_CHECKSUM_EN
    logic [31:0]       csum_q, csum_d;
`endif

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            shift_q <= '0;
            idx_q   <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
`ifdef MEM_DUMP_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        shift_d = shift_q;
        idx_d   = idx_q;
`ifdef MEM_DUMP_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = start_addr;
                    rem_d   = word_count;
`ifdef MEM_DUMP_CHECKSUM_EN
                    csum_d  = '0;
`endif
                    state_d = (word_count == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: state_d = S_WAIT;
            S_WAIT: begin
                shift_d = mem_rd_data;
                idx_d   = 2'd0;
`ifdef MEM_DUMP_CHECKSUM_EN
                csum_d  = csum_q ^ mem_rd_data;
`endif
                state_d = S_SEND;
            end
            S_SEND: begin
                if (out_ready) begin
                    if (idx_q != 2'd3) begin
                        shift_d = {shift_q[23:0], 8'h00};
                        idx_d   = idx_q + 2'd1;
                    end else begin
                        rem_d  = rem_q - CNT_W'(1);
                        addr_d = addr_q + ADDR_W'(1);
                        if (rem_q != CNT_W'(1)) begin
                            state_d = S_READ;
                        end else begin
`ifdef MEM_DUMP_CHECKSUM_EN
                            // Checksum already includes the last word, captured in WAIT.
                            shift_d = csum_q;
                            idx_d   = 2'd0;
                            state_d = S_CSUM;
`else
                            state_d = S_DONE;
`endif
                        end
                    end
                end
            end
`ifdef MEM_DUMP_CHECKSUM_EN
            S_CSUM: begin
                if (out_ready) begin
                    if (idx_q != 2'd3) begin
                        shift_d = {shift_q[23:0], 8'h00};
                        idx_d   = idx_q + 2'd1;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_rd_en   = (state_q == S_READ);
        mem_rd_addr = addr_q;
        out_data    = shift_q[31:24];
`ifdef MEM_DUMP_CHECKSUM_EN
        out_valid   = (state_q == S_SEND) || (state_q == S_CSUM);
`else
        out_valid   = (state_q == S_SEND);
`endif
        busy        = (state_q == S_READ) || (state_q == S_WAIT) || out_valid;
        done        = (state_q == S_DONE);
    end

endmodule
